// File: rtl/vmx_result_collector.sv
// Collects row-staggered products from the vmx PE array into whole result vectors.
// Results are queued in a FIFO and sent out on a valid/ready stream, and issue credits are returned to the feeder.
module vmx_result_collector #(
    parameter int SIZE           = 4,
    parameter int PRODUCT_BITLEN = 32,
    parameter int BASE_LAT       = 4,
    parameter int ROW_SKEW       = 1,
    parameter int DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [SIZE*PRODUCT_BITLEN-1:0]   product,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SIZE*PRODUCT_BITLEN-1:0]   out_data,
    output logic [$clog2(DEPTH):0]           occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Tap k of the token pipe is token_q[k-1]; tap 0 is the accepted issue itself.
    localparam int TOK_W = BASE_LAT + (SIZE - 1) * ROW_SKEW;

    logic [TOK_W-1:0]          token_q, token_d;
    logic [PTR_W-1:0]          row_wr_ptr_q [SIZE];
    logic [PTR_W-1:0]          row_wr_ptr_d [SIZE];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          reserved_q, reserved_d;
    logic [CNT_W-1:0]          occupancy_q, occupancy_d;
    logic [SIZE-1:0]           row_valid_q [DEPTH];
    logic [SIZE-1:0]           row_valid_d [DEPTH];
    logic [PRODUCT_BITLEN-1:0] mem [DEPTH][SIZE];
    logic [SIZE-1:0]           capture;
    logic                      issue_fire;
    logic                      pop;
    logic                      commit;

    assign issue_ready = (reserved_q < CNT_W'(DEPTH));
    assign out_valid   = (occupancy_q != '0);
    assign occupancy   = occupancy_q;
    assign issue_fire  = issue_valid & issue_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign commit      = capture[SIZE-1];

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_row
            assign capture[gi] = token_q[BASE_LAT + gi*ROW_SKEW - 1] & ~flush;
            assign out_data[gi*PRODUCT_BITLEN +: PRODUCT_BITLEN] =
                out_valid ? mem[rd_ptr_q][gi] : '0;

            // Credits bound in-flight vectors to DEPTH, so a slot is always free when its row arrives.
            assert property (@(posedge clk) disable iff (!rst_n)
                capture[gi] |-> !row_valid_q[row_wr_ptr_q[gi]][gi]);
        end
    endgenerate

    always_comb begin
        token_d      = (token_q << 1) | TOK_W'(issue_fire);
        reserved_d   = reserved_q;
        occupancy_d  = occupancy_q;
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        row_wr_ptr_d = row_wr_ptr_q;
        row_valid_d  = row_valid_q;

        if (issue_fire && !pop)
            reserved_d = reserved_q + CNT_W'(1);
        else if (!issue_fire && pop)
            reserved_d = reserved_q - CNT_W'(1);

        if (commit && !pop)
            occupancy_d = occupancy_q + CNT_W'(1);
        else if (!commit && pop)
            occupancy_d = occupancy_q - CNT_W'(1);

        if (pop)
            row_valid_d[rd_ptr_q] = '0;

        for (int i = 0; i < SIZE; i++) begin
            if (capture[i]) begin
                row_valid_d[row_wr_ptr_q[i]][i] = 1'b1;
                row_wr_ptr_d[i] = row_wr_ptr_q[i] + PTR_W'(1);
            end
        end

        // Flush drops everything in flight and stored, overriding issue and pop.
        if (flush) begin
            token_d     = '0;
            reserved_d  = '0;
            occupancy_d = '0;
            rd_ptr_d    = '0;
            for (int i = 0; i < SIZE; i++)
                row_wr_ptr_d[i] = '0;
            for (int d = 0; d < DEPTH; d++)
                row_valid_d[d] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            token_q     <= '0;
            reserved_q  <= '0;
            occupancy_q <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < SIZE; i++)
                row_wr_ptr_q[i] <= '0;
            for (int d = 0; d < DEPTH; d++)
                row_valid_q[d] <= '0;
        end else begin
            token_q      <= token_d;
            reserved_q   <= reserved_d;
            occupancy_q  <= occupancy_d;
            rd_ptr_q     <= rd_ptr_d;
            row_wr_ptr_q <= row_wr_ptr_d;
            row_valid_q  <= row_valid_d;
        end
    end

    // Result storage has no reset; out_data is gated by out_valid instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (capture[i])
                mem[row_wr_ptr_q[i]][i] <= product[i*PRODUCT_BITLEN +: PRODUCT_BITLEN];
        end
    end

endmodule

// File: tb/tb_vmx_result_collector.sv
// Randomized and directed bench for vmx_result_collector.
// A queue-based reference model predicts credits, occupancy and result rows from the product history.
module tb_vmx_result_collector;
    localparam int SIZE     = 4;
    localparam int PB       = 32;
    localparam int BASE_LAT = 4;
    localparam int ROW_SKEW = 1;
    localparam int DEPTH    = 4;
    localparam int LAT      = BASE_LAT + (SIZE - 1) * ROW_SKEW + 1;
    localparam int W        = SIZE * PB;
    localparam int MAXC     = 4000;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   issue_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   issue_ready;
    logic                   out_valid;
    logic [W-1:0]           product = '0;
    logic [W-1:0]           out_data;
    logic [$clog2(DEPTH):0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] prod_hist [MAXC];
    int q[$];   // issue cycles of vectors holding a credit, oldest first

    always #5 clk = ~clk;

    vmx_result_collector #(
        .SIZE(SIZE), .PRODUCT_BITLEN(PB), .BASE_LAT(BASE_LAT),
        .ROW_SKEW(ROW_SKEW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .product(product), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A vector is complete once LAT cycles have passed since it was accepted.
    function automatic int exp_occ();
        int n = 0;
        foreach (q[k]) if (q[k] + LAT <= cyc) n++;
        return n;
    endfunction

    // Row i of a vector issued at cycle t is whatever row i of the bus carried at t+BASE_LAT+i*ROW_SKEW.
    function automatic logic [W-1:0] exp_head();
        logic [W-1:0] v;
        logic [W-1:0] h;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            h = prod_hist[q[0] + BASE_LAT + i*ROW_SKEW];
            v[i*PB +: PB] = h[i*PB +: PB];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] rand_prod();
        logic [W-1:0] v;
        for (int i = 0; i < SIZE; i++) v[i*PB +: PB] = $urandom;
        return v;
    endfunction

    // Called just after a falling edge: drive inputs, check outputs, advance model and one clock.
    task automatic step(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] prod);
        int occ;
        logic fire;
        logic pop;
        issue_valid = iv;
        out_ready   = ordy;
        flush       = fl;
        product     = prod;
        prod_hist[cyc] = prod;
        occ = exp_occ();
        check_eq("issue_ready", W'(issue_ready), W'(q.size() < DEPTH));
        check_eq("out_valid", W'(out_valid), W'(occ != 0));
        check_eq("occupancy", W'(occupancy), W'(occ));
        check_eq("out_data", out_data, (occ != 0) ? exp_head() : '0);
        fire = iv && (q.size() < DEPTH) && !fl;
        pop  = (occ != 0) && ordy && !fl;
        if (pop) $display("cycle %0d pop: vector issued @%0d data %h", cyc, q[0], out_data);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (fire) q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_issue_ready", W'(issue_ready), W'(1));
        check_eq("rst_out_valid", W'(out_valid), W'(0));
        check_eq("rst_occupancy", W'(occupancy), W'(0));
        q.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] p2;
        logic [W-1:0] tagp;
        int t0;
        int fires;
        int vhigh;
        int run;
        int maxrun;

        #1;
        check_eq("init_issue_ready", W'(issue_ready), W'(1));
        check_eq("init_out_valid", W'(out_valid), W'(0));
        check_eq("init_occupancy", W'(occupancy), W'(0));
        check_eq("init_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single issue with fixed row values.
        p2 = {32'h44, 32'h33, 32'h22, 32'h11};
        t0 = cyc;
        step(1'b1, 1'b0, 1'b0, p2);
        while (cyc < t0 + LAT) begin
            if (cyc == t0 + LAT - 1) check_eq("single_not_yet", W'(out_valid), W'(0));
            step(1'b0, 1'b0, 1'b0, p2);
        end
        check_eq("single_valid", W'(out_valid), W'(1));
        check_eq("single_data", out_data, p2);
        step(1'b0, 1'b1, 1'b0, p2);
        step(1'b0, 1'b0, 1'b0, p2);

        // Back-to-back issues, each bus row tagged with the cycle number.
        vhigh = 0; run = 0; maxrun = 0;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < SIZE; i++) tagp[i*PB +: PB] = (cyc << 8) | i;
            if (out_valid) begin vhigh++; run++; end else run = 0;
            if (run > maxrun) maxrun = run;
            step(k < 4, 1'b1, 1'b0, tagp);
        end
        check_eq("b2b_valid_cycles", W'(vhigh), W'(4));
        check_eq("b2b_consecutive", W'(maxrun), W'(4));

        // Backpressure: consumer stalled, feeder keeps asking.
        fires = 0;
        for (int k = 0; k < 14; k++) begin
            if (issue_ready) fires++;
            step(1'b1, 1'b0, 1'b0, rand_prod());
        end
        check_eq("bp_accepted", W'(fires), W'(4));
        check_eq("bp_ready_low", W'(issue_ready), W'(0));
        check_eq("bp_occupancy", W'(occupancy), W'(4));
        // Release: pops with concurrent issues exercise the credit and commit/pop corner cases.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, rand_prod());
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, rand_prod());

        // Flush with one stored and two in flight.
        t0 = cyc;
        step(1'b1, 1'b0, 1'b0, rand_prod());
        while (cyc < t0 + LAT) step(1'b0, 1'b0, 1'b0, rand_prod());
        step(1'b1, 1'b0, 1'b0, rand_prod());
        step(1'b1, 1'b0, 1'b0, rand_prod());
        step(1'b0, 1'b0, 1'b0, rand_prod());
        step(1'b0, 1'b1, 1'b1, rand_prod());
        check_eq("flush_out_valid", W'(out_valid), W'(0));
        check_eq("flush_occupancy", W'(occupancy), W'(0));
        check_eq("flush_issue_ready", W'(issue_ready), W'(1));
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, rand_prod());

        // Random traffic with a mid-stream reset.
        for (int k = 0; k < 900; k++) begin
            if (k == 450) do_reset_mid();
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65,
                 $urandom_range(0, 199) == 0, rand_prod());
        end
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, rand_prod());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
